// File: rtl/scan_chain_ctrl.sv
// Scan-chain test sequencer: shifts a pattern in, pulses one functional capture, shifts the response out.
// Define SCAN_MISR_EN to compile in a 16-bit MISR over the unloaded stream; otherwise sig is tied to 0.
module scan_chain_ctrl #(
  parameter int n    = 8,
  parameter int tphl = 0,
  parameter int tplh = 0
) (
  input  logic         C,
  input  logic         global_reset_n,
  input  logic         start,
  input  logic [n-1:0] pat_in,
  input  logic         So,
  output logic         NbarT,
  output logic         Si,
  output logic         CE,
  output logic         busy,
  output logic [n-1:0] resp_out,
  output logic         resp_valid,
  output logic [15:0]  sig
);

  localparam int            CW   = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [n-1:0]  r_pat, w_pat_nxt, w_pat_shifted;
  logic [n-1:0]  r_shift, r_resp;
  logic          w_accept;
  logic          r_nbart, r_si, r_ce, r_busy, r_resp_valid;
  logic          w_nbart_nxt, w_si_nxt, w_ce_nxt, w_busy_nxt, w_resp_valid_nxt;
  logic          w_unused_delay;

  // Delay parameters exist only so library netlists can pass them through.
  assign w_unused_delay = (tphl + tplh) != 0;

  // State register; outputs are registered alongside it from next-state values.
  always_ff @(posedge C) begin
    if (!global_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pat        <= '0;
      r_nbart      <= 1'b0;
      r_si         <= 1'b0;
      r_ce         <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pat        <= w_pat_nxt;
      r_nbart      <= w_nbart_nxt;
      r_si         <= w_si_nxt;
      r_ce         <= w_ce_nxt;
      r_busy       <= w_busy_nxt;
      r_resp_valid <= w_resp_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    if (r_cnt == LAST) w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = UNLOAD;
      UNLOAD:  if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // The counter restarts on every state entry and only advances in the shifting states.
    if ((w_state_nxt != r_state) || w_accept)
      w_cnt_nxt = '0;
    else if ((r_state == LOAD) || (r_state == UNLOAD))
      w_cnt_nxt = r_cnt + CW'(1);
    else
      w_cnt_nxt = r_cnt;

    w_pat_nxt = w_accept ? pat_in : r_pat;
  end

  // Output logic, computed for the state about to be entered.
  // NOTE: decoding the next state and registering it keeps every output a flop with no input-to-output path.
  always_comb begin
    w_pat_shifted    = w_pat_nxt << w_cnt_nxt;
    w_nbart_nxt      = (w_state_nxt == LOAD) || (w_state_nxt == UNLOAD);
    w_ce_nxt         = (w_state_nxt == CAPTURE);
    w_si_nxt         = (w_state_nxt == LOAD) && w_pat_shifted[n-1];
    w_busy_nxt       = (w_state_nxt != IDLE);
    w_resp_valid_nxt = (w_state_nxt == DONE);
  end

  // Response is assembled in r_shift and published only when the last bit arrives.
  always_ff @(posedge C) begin
    if (!global_reset_n) begin
      r_shift <= '0;
      r_resp  <= '0;
    end else if (r_state == UNLOAD) begin
      r_shift <= {r_shift[n-2:0], So};
      if (r_cnt == LAST) r_resp <= {r_shift[n-2:0], So};
    end
  end

`ifdef SCAN_MISR_EN
  logic [15:0] r_sig;
  logic        w_fb;

  // Galois form of x^16+x^12+x^5+1 with the scan-out bit folded into the feedback.
  assign w_fb = r_sig[15] ^ So;

  always_ff @(posedge C) begin
    if (!global_reset_n)
      r_sig <= '0;
    else if (r_state == UNLOAD)
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
  end

  assign sig = r_sig;
`else
  assign sig = 16'h0000;
`endif

  assign NbarT      = r_nbart;
  assign Si         = r_si;
  assign CE         = r_ce;
  assign busy       = r_busy;
  assign resp_out   = r_resp;
  assign resp_valid = r_resp_valid;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop chain with D = ~Q, expected responses queued at start and
// checked when resp_valid pulses.
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic         C = 1'b0;
  logic         global_reset_n;
  logic         start;
  logic [N-1:0] pat_in;
  logic         So;
  logic         NbarT, Si, CE, busy, resp_valid;
  logic [N-1:0] resp_out;
  logic [15:0]  sig;

  logic [N-1:0] chain = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_valid = 0;
  logic [15:0]  model_sig = '0;

  typedef struct {
    logic [N-1:0] resp;
    int           t_acc;
  } exp_t;

  exp_t sb_q[$];

  scan_chain_ctrl #(.n(N), .tphl(0), .tplh(0)) dut (
    .C              (C),
    .global_reset_n (global_reset_n),
    .start          (start),
    .pat_in         (pat_in),
    .So             (So),
    .NbarT          (NbarT),
    .Si             (Si),
    .CE             (CE),
    .busy           (busy),
    .resp_out       (resp_out),
    .resp_valid     (resp_valid),
    .sig            (sig)
  );

  always #5 C = ~C;

  always @(posedge C) cyc <= cyc + 1;

  // Chain of muxed-scan flops: capture inverts every flop, shift moves Si toward So.
  always @(posedge C) begin
    if (CE)         chain <= ~chain;
    else if (NbarT) chain <= {chain[N-2:0], Si};
  end

  assign So = chain[N-1];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

`ifdef SCAN_MISR_EN
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction
`endif

  // Scoreboard side: pop one expectation per resp_valid pulse.
  always @(negedge C) begin
    if (!global_reset_n) model_sig = '0;
    check("nbart_ce_excl", 32'(NbarT & CE), 0);
    if (resp_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check("spurious_valid", 32'(resp_valid), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_out", 32'(resp_out), 32'(e.resp));
        check("valid_latency", cyc + 1 - e.t_acc, 2 * N + 2);
`ifdef SCAN_MISR_EN
        for (int i = N - 1; i >= 0; i--) model_sig = misr_step(model_sig, e.resp[i]);
        check("sig_misr", 32'(sig), 32'(model_sig));
`else
        check("sig_zero", 32'(sig), 0);
`endif
      end
    end
  end

  task automatic issue(input logic [N-1:0] p);
    exp_t e;
    start  = 1'b1;
    pat_in = p;
    e.resp  = ~p;
    e.t_acc = cyc + 1;
    sb_q.push_back(e);
    @(negedge C);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!resp_valid && k < 4 * N + 8) begin
      @(negedge C);
      k++;
    end
    check({tag, "_seen"}, 32'(resp_valid), 1);
  endtask

  logic [N-1:0] wp;
  logic [4:0]   exp_w;
  int           n_nbart, n_ce, v0;

  initial begin
    global_reset_n = 1'b0;
    start          = 1'b0;
    pat_in         = '0;
    repeat (3) @(negedge C);
    check("rst_ctrl", 32'({NbarT, Si, CE, busy, resp_valid}), 0);
    check("rst_resp", 32'(resp_out), 0);
    check("rst_sig", 32'(sig), 0);
    #1 global_reset_n = 1'b1;
    @(negedge C);

    // A5 from reset, with a cycle-by-cycle waveform check.
    wp = 8'hA5;
    issue(wp);
    n_nbart = 0;
    n_ce    = 0;
    for (int o = 1; o <= 2 * N + 2; o++) begin
      if (o <= N)              exp_w = {1'b1, 1'b0, wp[N-o], 1'b1, 1'b0};
      else if (o == N + 1)     exp_w = 5'b01010;
      else if (o <= 2 * N + 1) exp_w = 5'b10010;
      else                     exp_w = 5'b00011;
      check($sformatf("wave_o%0d", o), 32'({NbarT, CE, Si, busy, resp_valid}), 32'(exp_w));
      n_nbart += int'(NbarT);
      n_ce    += int'(CE);
      @(negedge C);
    end
    check("nbart_cycles", n_nbart, 2 * N);
    check("ce_cycles", n_ce, 1);
    check("resp_hold", 32'(resp_out), 'h5A);
    check("idle_busy", 32'(busy), 0);

    // Back-to-back: 00 then FF, second start issued in DONE.
    issue(8'h00);
    wait_valid("b2b_first");
    issue(8'hFF);
    check("b2b_no_idle", 32'({busy, NbarT}), 'b11);
    wait_valid("b2b_second");
    @(negedge C);

    // A start during LOAD with a different pattern must be ignored.
    issue(8'h96);
    repeat (2) @(negedge C);
    start  = 1'b1;
    pat_in = 8'h0F;
    repeat (2) @(negedge C);
    start = 1'b0;
    repeat (9) @(negedge C);
    check("resp_no_partial", 32'(resp_out), 'h00);
    v0 = n_valid;
    wait_valid("ignored_start");
    repeat (6) @(negedge C);
    check("single_valid", n_valid - v0, 1);

    // Reset during UNLOAD cycle 3 aborts the sequence.
    issue(8'h3C);
    repeat (12) @(negedge C);
    check("abort_in_unload", 32'({NbarT, CE, busy}), 'b101);
    global_reset_n = 1'b0;
    sb_q.delete();
    v0 = n_valid;
    @(negedge C);
    check("abort_ctrl", 32'({NbarT, Si, CE, busy, resp_valid}), 0);
    check("abort_resp", 32'(resp_out), 0);
    check("abort_sig", 32'(sig), 0);
    #1 global_reset_n = 1'b1;
    repeat (10) @(negedge C);
    check("abort_no_valid", n_valid - v0, 0);

    issue(8'hC3);
    wait_valid("after_abort");
    repeat (3) @(negedge C);
    check("queue_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter n, default 8: scan chain length in flops; SHALL be >= 2.
REQ-002 Parameter tphl, default 0, and parameter tplh, default 0: output delay parameters, carried for library compatibility; they SHALL NOT change cycle behaviour.
REQ-003 C, input, 1: the only clock; all state SHALL update on posedge C.
REQ-004 global_reset_n, input, 1: synchronous active-low reset, sampled on posedge C.
REQ-005 start, input, 1: request one load/capture/unload test sequence.
REQ-006 pat_in, input, n: test pattern; bit i targets chain flop i, where flop 0 is nearest Si.
REQ-007 So, input, 1: scan-out, the Q of chain flop n-1.
REQ-008 NbarT, output, 1: drives NbarT of every dff in the chain; 1 = shift.
REQ-009 Si, output, 1: serial scan data into chain flop 0.
REQ-010 CE, output, 1: drives CE of every dff in the chain; 1 = functional capture.
REQ-011 busy, output, 1: high whenever the state is not IDLE.
REQ-012 resp_out, output, n: captured response; bit i = the value flop i held after capture.
REQ-013 resp_valid, output, 1: single-cycle pulse marking resp_out valid.
REQ-014 sig, output, 16: serial signature register (MISR) of the unloaded bits; see Configuration.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE: latch pat_in, clear the bit counter, enter LOAD.
REQ-017 start SHALL be ignored in LOAD, CAPTURE and UNLOAD.
REQ-018 LOAD SHALL last exactly n cycles with NbarT=1 and CE=0, and Si = pat_in[n-1-k] in LOAD cycle k (MSB first).
REQ-019 After LOAD, the FSM SHALL enter CAPTURE for exactly 1 cycle with NbarT=0, CE=1, Si=0.
REQ-020 UNLOAD SHALL last exactly n cycles with NbarT=1, CE=0, Si=0; in cycle k, So SHALL be sampled at the closing edge into resp_out[n-1-k].
REQ-021 DONE SHALL last 1 cycle with resp_valid=1, then go to IDLE (or to LOAD if start is accepted).
REQ-022 Latency: start accepted at edge t gives LOAD in cycles t+1..t+n, CAPTURE at t+n+1, UNLOAD at t+n+2..t+2n+1, resp_valid at t+2n+2.
REQ-023 In IDLE and DONE, NbarT=0, CE=0 and Si=0, so the chain holds.
REQ-024 resp_out SHALL hold its value from DONE until the next UNLOAD completes; it SHALL NOT show partial updates outside UNLOAD.
REQ-025 The bit counter SHALL be ceil(log2(n+1)) bits wide and SHALL be cleared on every state entry; it SHALL NOT wrap within a state.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 When global_reset_n=0 at posedge C: state = IDLE; NbarT, Si, CE, busy and resp_valid = 0; resp_out = 0; sig = 0; counter = 0.
REQ-028 Reset SHALL take priority over start and over any in-progress sequence; a sequence aborted mid-LOAD or mid-UNLOAD SHALL NOT raise resp_valid.

Configuration
REQ-029 Macro SCAN_MISR_EN, when defined: on every UNLOAD cycle, sig SHALL update as a 16-bit LFSR with polynomial x^16+x^12+x^5+1, feedback XORed with So.
REQ-030 With SCAN_MISR_EN defined, sig SHALL accumulate across sequences and clear only on reset.
REQ-031 With SCAN_MISR_EN undefined, sig SHALL be constant 0 and no MISR logic SHALL exist; the port list SHALL be identical in both builds.

Verification
REQ-032 n=8, chain of 8 dff with D_i = ~Q_i; start with pat_in=8'hA5 -> resp_out=8'h5A with resp_valid pulse exactly 18 cycles after the start edge.
REQ-033 Same bench with pat_in=8'h00, then 8'hFF back-to-back (start asserted in DONE) -> resp_out 8'hFF, then 8'h00; no idle cycle between sequences.
REQ-034 start re-asserted during LOAD with a different pat_in -> ignored; the original response is returned and only one resp_valid pulse occurs.
REQ-035 global_reset_n=0 for 1 cycle at UNLOAD cycle 3 -> all outputs at reset values next cycle, no resp_valid, the next start runs a full sequence.
REQ-036 SCAN_MISR_EN defined, pat_in=8'hA5 sequence from reset -> sig matches the reference-model LFSR value; build without the macro -> sig=16'h0000 throughout.
REQ-037 Cycle-check NbarT/CE waveform: NbarT=1 for 8 cycles, CE=1 for exactly 1 cycle, NbarT=1 for 8 cycles; NbarT and CE are never high in the same cycle.
